// File: rtl/forward_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// forward_hazard_ctrl_if
//   Bundle between the LEGv8 pipeline datapath and forward_hazard_ctrl.
//   master : the datapath side. It drives the ID-stage register fields and
//            dmem_wait, and consumes the forwarding selects and interlocks.
//   slave  : the controller side.
//
//   ID_Rn/ID_Rm    source registers of the instruction in ID
//   ID_Rd          destination register of the instruction in ID
//   ID_RegWrite    ID instruction writes the register file
//   ID_MemRead     ID instruction is a load
//   dmem_wait      data memory not ready, so the whole pipeline holds
//   ForwardA/B     EX operand selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall          hold PC and IF/ID
//   bubble         load NOP controls into ID/EX
//   freeze         hold every pipeline register
//   stall_cycles   saturating count of stall/freeze cycles
// ---------------------------------------------------------------------------
interface forward_hazard_ctrl_if;
  logic [4:0]  ID_Rn;
  logic [4:0]  ID_Rm;
  logic [4:0]  ID_Rd;
  logic        ID_RegWrite;
  logic        ID_MemRead;
  logic        dmem_wait;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        stall;
  logic        bubble;
  logic        freeze;
  logic [15:0] stall_cycles;

  modport master (
    output ID_Rn, ID_Rm, ID_Rd, ID_RegWrite, ID_MemRead, dmem_wait,
    input  ForwardA, ForwardB, stall, bubble, freeze, stall_cycles
  );

  modport slave (
    input  ID_Rn, ID_Rm, ID_Rd, ID_RegWrite, ID_MemRead, dmem_wait,
    output ForwardA, ForwardB, stall, bubble, freeze, stall_cycles
  );
endinterface

// File: rtl/forward_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// forward_hazard_ctrl
//   EX-stage forwarding and interlock controller for the LEGv8 5-stage core.
//   The controller keeps a shadow copy of the destination-register state of
//   the instructions in EX and MEM. It produces registered ForwardA/ForwardB
//   selects that line up with the instruction in EX. It also produces the
//   combinational stall, bubble and freeze controls.
//
//   Ports:
//     clk      pipeline clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      forward_hazard_ctrl_if.slave (ID fields, dmem_wait in;
//              ForwardA/B, stall, bubble, freeze, stall_cycles out)
//
//   Build option:
//     FORWARDING_EN  defined   : EX/MEM and MEM/WB forwarding. Only a
//                                load-use inserts a bubble.
//     FORWARDING_EN  undefined : ForwardA/B are always 00. Any producer in
//                                EX or MEM interlocks until it reaches WB.
//
//   A producer in WB is not tracked. The register file writes before it
//   reads, so a WB-stage destination never needs a forward or a stall.
// ---------------------------------------------------------------------------
module forward_hazard_ctrl (
  input  logic                        clk,
  input  logic                        reset_n,
  forward_hazard_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LOADUSE = 2'b01,
    MEMWAIT = 2'b10
  } state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } ex_stage_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
  } mem_stage_t;

  localparam logic [4:0] XZR = 5'd31;

  state_e      r_state;
  state_e      w_state_nxt;
  ex_stage_t   r_ex;
  mem_stage_t  r_mem;
  logic [1:0]  r_fwd_a;
  logic [1:0]  r_fwd_b;
  logic [15:0] r_stall_cycles;

  logic        w_stall;
  logic        w_bubble;
  logic        w_freeze;
  logic        w_hazard;
  logic [1:0]  w_fwd_a_nxt;
  logic [1:0]  w_fwd_b_nxt;

  // XZR always reads as zero, so it never has a real producer.
  function automatic logic match(input logic [4:0] src, input logic [4:0] rd,
                                 input logic we);
    return we && (rd == src) && (src != XZR);
  endfunction

  logic w_ex_hit_a, w_ex_hit_b, w_mem_hit_a, w_mem_hit_b;
  assign w_ex_hit_a  = match(bus.ID_Rn, r_ex.rd,  r_ex.reg_write);
  assign w_ex_hit_b  = match(bus.ID_Rm, r_ex.rd,  r_ex.reg_write);
  assign w_mem_hit_a = match(bus.ID_Rn, r_mem.rd, r_mem.reg_write);
  assign w_mem_hit_b = match(bus.ID_Rm, r_mem.rd, r_mem.reg_write);

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time.
  assign w_hazard    = r_ex.mem_read && (w_ex_hit_a || w_ex_hit_b);
  // EX/MEM holds the younger result, so it wins over MEM/WB.
  assign w_fwd_a_nxt = w_ex_hit_a ? 2'b10 : (w_mem_hit_a ? 2'b01 : 2'b00);
  assign w_fwd_b_nxt = w_ex_hit_b ? 2'b10 : (w_mem_hit_b ? 2'b01 : 2'b00);
`else
  // Without forward paths, every in-flight producer interlocks. A load in EX
  // is one case of the EX match and is listed for symmetry with the
  // forwarding build.
  assign w_hazard    = (r_ex.mem_read && (w_ex_hit_a || w_ex_hit_b)) ||
                       w_ex_hit_a || w_ex_hit_b || w_mem_hit_a || w_mem_hit_b;
  assign w_fwd_a_nxt = 2'b00;
  assign w_fwd_b_nxt = 2'b00;
`endif

  // Each state evaluates the same way. LOADUSE lasts one cycle, and MEMWAIT
  // resumes normal evaluation in the cycle dmem_wait drops. The state mostly
  // records why the pipeline is held.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_freeze    = 1'b0;
    unique case (r_state)
      RUN, LOADUSE, MEMWAIT: begin
        if (bus.dmem_wait) begin
          // A memory wait wins over load-use: freeze everything, no bubble.
          w_state_nxt = MEMWAIT;
          w_freeze    = 1'b1;
          w_stall     = 1'b1;
        end else if (w_hazard) begin
          w_state_nxt = LOADUSE;
          w_stall     = 1'b1;
          w_bubble    = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignment, so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= RUN;
      r_ex           <= '0;
      r_mem          <= '0;
      r_fwd_a        <= 2'b00;
      r_fwd_b        <= 2'b00;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((w_stall || w_freeze) && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;

      if (!w_freeze) begin
        r_mem.rd        <= r_ex.rd;
        r_mem.reg_write <= r_ex.reg_write;
        if (w_bubble) begin
          r_ex    <= '0;
          r_fwd_a <= 2'b00;
          r_fwd_b <= 2'b00;
        end else begin
          r_ex.rd        <= bus.ID_Rd;
          r_ex.reg_write <= bus.ID_RegWrite;
          r_ex.mem_read  <= bus.ID_MemRead;
          r_fwd_a        <= w_fwd_a_nxt;
          r_fwd_b        <= w_fwd_b_nxt;
        end
      end
    end
  end

  assign bus.ForwardA     = r_fwd_a;
  assign bus.ForwardB     = r_fwd_b;
  assign bus.stall        = w_stall;
  assign bus.bubble       = w_bubble;
  assign bus.freeze       = w_freeze;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_forward_hazard_ctrl
//   Directed bench for forward_hazard_ctrl. The expected ForwardA/B and
//   stall_cycles values for each cycle are queued when the ID inputs are
//   driven. They are popped after the clock edge that moves the instruction
//   into EX. stall, bubble and freeze are checked combinationally on the
//   falling edge. The expectations follow the FORWARDING_EN build setting.
// ---------------------------------------------------------------------------
module tb_forward_hazard_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  forward_hazard_ctrl_if bus ();

  forward_hazard_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef FORWARDING_EN
  localparam logic [15:0] SC_L1 = 16'd1;
`else
  localparam logic [15:0] SC_L1 = 16'd2;
`endif

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rn, input logic [4:0] rm,
                        input logic [4:0] rd, input logic rw, input logic mr);
    bus.ID_Rn       = rn;
    bus.ID_Rm       = rm;
    bus.ID_Rd       = rd;
    bus.ID_RegWrite = rw;
    bus.ID_MemRead  = mr;
  endtask

  task automatic check_comb(input string tag, input logic st, input logic bu,
                            input logic fr);
    check({tag, ".stall"},  16'(bus.stall),  16'(st));
    check({tag, ".bubble"}, 16'(bus.bubble), 16'(bu));
    check({tag, ".freeze"}, 16'(bus.freeze), 16'(fr));
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".fwdA"}, 16'(bus.ForwardA), 16'(e.fa));
      check({e.tag, ".fwdB"}, 16'(bus.ForwardB), 16'(e.fb));
      check({e.tag, ".cnt"},  bus.stall_cycles,  e.sc);
    end
  endtask

  // The caller enters just after a rising edge with the inputs already set.
  task automatic tick(input string tag, input logic [1:0] fa,
                      input logic [1:0] fb, input logic st, input logic bu,
                      input logic fr, input logic [15:0] sc);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb; e.sc = sc;
    sb_q.push_back(e);
    @(negedge clk);
    check_comb(tag, st, bu, fr);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    bus.dmem_wait = 1'b0;
    set_id(5'd31, 5'd31, 5'd31, 1'b0, 1'b0);
    #2;
    check_comb("rst", 1'b0, 1'b0, 1'b0);
    check("rst.fwdA", 16'(bus.ForwardA), 16'd0);
    check("rst.fwdB", 16'(bus.ForwardB), 16'd0);
    check("rst.cnt",  bus.stall_cycles, 16'd0);
    bus.dmem_wait = 1'b1;
    #1;
    check_comb("rst_wait", 1'b1, 1'b0, 1'b1);
    bus.dmem_wait = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef FORWARDING_EN
    set_id(5'd2,  5'd3,  5'd1,  1'b1, 1'b0); tick("add_x1",   2'b00, 2'b00, 0, 0, 0, 16'd0);
    set_id(5'd1,  5'd3,  5'd2,  1'b1, 1'b0); tick("sub_fwdA", 2'b10, 2'b00, 0, 0, 0, 16'd0);
    set_id(5'd6,  5'd7,  5'd1,  1'b1, 1'b0); tick("add_x1b",  2'b00, 2'b00, 0, 0, 0, 16'd0);
    set_id(5'd31, 5'd31, 5'd31, 1'b0, 1'b0); tick("nop",      2'b00, 2'b00, 0, 0, 0, 16'd0);
    set_id(5'd5,  5'd1,  5'd4,  1'b1, 1'b0); tick("orr_fwdB", 2'b00, 2'b01, 0, 0, 0, 16'd0);
    set_id(5'd2,  5'd3,  5'd31, 1'b1, 1'b0); tick("add_xzr",  2'b00, 2'b00, 0, 0, 0, 16'd0);
    set_id(5'd31, 5'd4,  5'd8,  1'b1, 1'b0); tick("rd_xzr",   2'b00, 2'b01, 0, 0, 0, 16'd0);
    set_id(5'd1,  5'd2,  5'd8,  1'b1, 1'b0); tick("add_x8",   2'b00, 2'b00, 0, 0, 0, 16'd0);
    set_id(5'd8,  5'd0,  5'd9,  1'b1, 1'b0); tick("prio",     2'b10, 2'b00, 0, 0, 0, 16'd0);
    set_id(5'd2,  5'd31, 5'd9,  1'b1, 1'b1); tick("ldur_x9",  2'b00, 2'b00, 0, 0, 0, 16'd0);
    set_id(5'd9,  5'd9,  5'd10, 1'b1, 1'b0); tick("lu_bub",   2'b00, 2'b00, 1, 1, 0, 16'd1);
    tick("lu_fwd", 2'b01, 2'b01, 0, 0, 0, 16'd1);
`else
    set_id(5'd2,  5'd3,  5'd1,  1'b1, 1'b0); tick("add_x1",   2'b00, 2'b00, 0, 0, 0, 16'd0);
    set_id(5'd1,  5'd3,  5'd2,  1'b1, 1'b0); tick("nf_ex",    2'b00, 2'b00, 1, 1, 0, 16'd1);
    tick("nf_mem", 2'b00, 2'b00, 1, 1, 0, 16'd2);
    tick("nf_rel", 2'b00, 2'b00, 0, 0, 0, 16'd2);
    set_id(5'd4,  5'd5,  5'd31, 1'b1, 1'b0); tick("add_xzr",  2'b00, 2'b00, 0, 0, 0, 16'd2);
    set_id(5'd31, 5'd31, 5'd5,  1'b1, 1'b0); tick("rd_xzr",   2'b00, 2'b00, 0, 0, 0, 16'd2);
`endif

    // Reset asserted while a load-use interlock is pending.
    set_id(5'd2, 5'd31, 5'd9, 1'b1, 1'b1);   tick("ldur_x9b", 2'b00, 2'b00, 0, 0, 0, SC_L1);
    set_id(5'd9, 5'd9, 5'd10, 1'b1, 1'b0);
    @(negedge clk);
    check_comb("lu_pre_rst", 1'b1, 1'b1, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check_comb("lu_in_rst", 1'b0, 1'b0, 1'b0);
    check("lu_in_rst.fwdA", 16'(bus.ForwardA), 16'd0);
    check("lu_in_rst.fwdB", 16'(bus.ForwardB), 16'd0);
    check("lu_in_rst.cnt",  bus.stall_cycles, 16'd0);
    @(posedge clk);
    #1;
    check("rst_hold.cnt", bus.stall_cycles, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_comb("post_rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // dmem_wait arrives together with a load-use hazard.
    set_id(5'd3,  5'd31, 5'd11, 1'b1, 1'b1); tick("ld_x11", 2'b00, 2'b00, 0, 0, 0, 16'd0);
    set_id(5'd11, 5'd1,  5'd12, 1'b1, 1'b0);
    bus.dmem_wait = 1'b1;
    tick("mw1", 2'b00, 2'b00, 1, 0, 1, 16'd1);
    tick("mw2", 2'b00, 2'b00, 1, 0, 1, 16'd2);
    tick("mw3", 2'b00, 2'b00, 1, 0, 1, 16'd3);
    bus.dmem_wait = 1'b0;
    tick("mw_lu", 2'b00, 2'b00, 1, 1, 0, 16'd4);
`ifdef FORWARDING_EN
    tick("mw_fwd", 2'b01, 2'b00, 0, 0, 0, 16'd4);
    set_id(5'd12, 5'd12, 5'd13, 1'b1, 1'b0); tick("fwd_ex2", 2'b10, 2'b10, 0, 0, 0, 16'd4);
    set_id(5'd31, 5'd31, 5'd31, 1'b0, 1'b0);
    bus.dmem_wait = 1'b1;
    tick("frz_hold", 2'b10, 2'b10, 1, 0, 1, 16'd5);
    bus.dmem_wait = 1'b0;
    tick("post_frz", 2'b00, 2'b00, 0, 0, 0, 16'd5);
`else
    tick("nf_mw_mem", 2'b00, 2'b00, 1, 1, 0, 16'd5);
    tick("nf_mw_rel", 2'b00, 2'b00, 0, 0, 0, 16'd5);
`endif

    // A long memory wait drives the counter into saturation.
    set_id(5'd31, 5'd31, 5'd31, 1'b0, 1'b0);
    bus.dmem_wait = 1'b1;
    repeat (65529) @(posedge clk);
    #1;
    check("sat_fffe.cnt", bus.stall_cycles, 16'hFFFE);
    check("sat.freeze", 16'(bus.freeze), 16'd1);
    @(posedge clk);
    #1;
    check("sat_ffff.cnt", bus.stall_cycles, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold.cnt", bus.stall_cycles, 16'hFFFF);
    bus.dmem_wait = 1'b0;
    #1;
    check_comb("sat_rel", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/forward_hazard_ctrl.md
# forward_hazard_ctrl

Sequencing controller for the EX-stage operand forwarding muxes and pipeline interlocks of the LEGv8 five-stage core. Tracks destination-register state of the in-flight EX/MEM/WB instructions in its own shadow pipeline and produces registered ForwardA/ForwardB selects aligned with the instruction in EX. Detects load-use hazards and data-memory wait conditions, and drives stall, bubble and freeze controls to the PC, IF/ID and ID/EX registers.

## Interface
- No parameters; register index width fixed at 5, XZR index fixed at 31.
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ID_Rn  in  5  first source register of instruction in ID
- ID_Rm  in  5  second source register of instruction in ID
- ID_Rd  in  5  destination register of instruction in ID
- ID_RegWrite  in  1  ID instruction writes register file
- ID_MemRead  in  1  ID instruction is a load
- dmem_wait  in  1  data memory not ready; whole pipeline must hold
- ForwardA  out  2  EX operand A select: 00 regfile, 01 MEM/WB result, 10 EX/MEM ALU result
- ForwardB  out  2  EX operand B select, same encoding
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load zeros (NOP controls) into ID/EX
- freeze  out  1  hold every pipeline register including ID/EX, EX/MEM, MEM/WB
- stall_cycles  out  16  saturating count of cycles with stall or freeze asserted

## Operation
- Shadow pipeline: EX_{Rd,RegWrite,MemRead}, MEM_{Rd,RegWrite}, WB_{Rd,RegWrite}.
- States: RUN, LOADUSE, MEMWAIT (2-bit encoding 00/01/10).
- Match(src, stg) = stg_RegWrite && stg_Rd == src && src != 31.
- RUN, dmem_wait=1 -> MEMWAIT. freeze=1, stall=1, bubble=0; all shadow registers, ForwardA/B hold.
- RUN, EX_MemRead && (Match(ID_Rn,EX) || Match(ID_Rm,EX)) -> LOADUSE. stall=1, bubble=1 combinationally; on the edge shadow EX loads zeros (bubble), MEM<=EX, WB<=MEM; ForwardA/B <= 00.
- RUN, otherwise advance: EX<=ID fields, MEM<=EX, WB<=MEM; ForwardX <= 10 if Match(src,EX), else 01 if Match(src,MEM), else 00 (EX/MEM priority over MEM/WB).
- LOADUSE: single cycle; hazard re-evaluated as in RUN (load now in MEM, so forward 01 follows). Returns to RUN, or MEMWAIT if dmem_wait.
- MEMWAIT: remain while dmem_wait=1; on dmem_wait=0 return to RUN and evaluate normally that same cycle (outputs for RUN become valid combinationally in the cycle dmem_wait drops).
- dmem_wait dominates load-use when simultaneous: freeze, no bubble.
- stall_cycles increments each cycle stall|freeze is 1, saturates at 16'hFFFF.
- WB-stage writes rely on register-file write-before-read; no WB forwarding.

## Timing
- stall, bubble, freeze: combinational from inputs and state, same cycle.
- ForwardA/B: registered; value computed while instruction is in ID, presented the cycle it is in EX (latency 1 edge).
- Load-use costs exactly one bubble cycle; each dmem_wait cycle costs one freeze cycle.
- Reset (any time, asynchronous): state=RUN, all shadow RegWrite/MemRead/Rd=0, ForwardA=ForwardB=00, stall_cycles=0; stall/bubble/freeze=0 unless dmem_wait=1 (freeze/stall follow input). Reset mid-stall discards the pending hazard.

## Configuration
- FORWARDING_EN defined: behaviour above.
- FORWARDING_EN undefined: ForwardA/B tied 00; any Match(src,EX) or Match(src,MEM) on ID_Rn/ID_Rm causes stall+bubble (LOADUSE state reused) until producer reaches WB; MemRead distinction unused. dmem_wait handling and stall_cycles unchanged.

## Test plan
- ADD X1 in ID, then SUB X2,X1,X3 -> next cycle SUB in EX with ForwardA=10, ForwardB=00, no stall.
- ADD X1; NOP; ORR X4,X5,X1 -> ForwardB=01 when ORR in EX; ADD X31 producer with reader of X31 -> ForwardA=00.
- LDUR X9 then ADD X10,X9,X9 -> one cycle stall=1, bubble=1, stall_cycles=1; then ForwardA=ForwardB=01.
- dmem_wait high 3 cycles concurrent with load-use -> freeze=1 3 cycles, bubble=0 throughout, then one bubble cycle; stall_cycles=4.
- reset_n pulsed low during LOADUSE -> outputs 00/0, stall_cycles=0, state RUN; stall_cycles forced near 16'hFFFE saturates at 16'hFFFF.
- FORWARDING_EN undefined, ADD X1 then SUB X2,X1,X3 -> 2 bubble cycles, ForwardA stays 00.
